shifter_left_seq_32_bits: RTL and testbench

SHIFTER_LEFT_SEQ_32_BITS -- requirements
Module: shifter_left_seq_32_bits

---
 rtl/shifter_left_seq_32_bits.sv | 86 ++++++++
 tb/tb_shifter_left_seq_32_bits.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_left_seq_32_bits.sv
// Sequential 32-bit left shifter: captures In/Sel on Start, shifts over several cycles, pulses Done with Out.
// Define SHIFTER_LEFT_FAST_EN to shift up to 4 bit positions per cycle instead of 1.
module shifter_left_seq_32_bits (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [31:0] In,
    input  logic [31:0] Sel,
    output logic [31:0] Out,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  count_q, count_d;
    logic [4:0]  step;
    logic [31:0] out_d;
    logic        done_d;

`ifdef SHIFTER_LEFT_FAST_EN
    assign step = (count_q > 5'd4) ? 5'd4 : count_q;
`else
    assign step = 5'd1;
`endif

    assign Busy = (state_q != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch behind.
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        out_d   = Out;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = SHIFT;
                    // Any amount of 32 or more empties the word, so skip straight to a zero result.
                    if (Sel[31:5] == 27'd0) begin
                        data_d  = In;
                        count_d = Sel[4:0];
                    end else begin
                        data_d  = 32'd0;
                        count_d = 5'd0;
                    end
                end
            end
            SHIFT: begin
                if (count_q != 5'd0) begin
                    data_d  = data_q << step;
                    count_d = count_q - step;
                end else begin
                    out_d   = data_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (Rst) begin
            state_q <= IDLE;
            data_q  <= 32'd0;
            count_q <= 5'd0;
            Out     <= 32'd0;
            Done    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            Out     <= out_d;
            Done    <= done_d;
        end
    end

endmodule

// File: tb/tb_shifter_left_seq_32_bits.sv
// Self-checking bench for shifter_left_seq_32_bits: vector table plus busy-ignore, reset-abort
// and back-to-back sequences. Latency expectations follow SHIFTER_LEFT_FAST_EN when defined.
module tb_shifter_left_seq_32_bits;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [31:0] In;
    logic [31:0] Sel;
    logic [31:0] Out;
    logic        Busy;
    logic        Done;

    int tests = 0;
    int fails = 0;

    shifter_left_seq_32_bits dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .In    (In),
        .Sel   (Sel),
        .Out   (Out),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] s;
        logic [31:0] exp_out;
        int          n;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_k(input int n);
`ifdef SHIFTER_LEFT_FAST_EN
        return (n + 3) / 4;
`else
        return n;
`endif
    endfunction

    // Issue one operation, scramble inputs after acceptance, and wait (bounded) for Done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] s,
                          output int lat, output logic [31:0] res, output logic busy_acc,
                          output logic busy_done, output logic done_after, output logic [31:0] out_after);
        @(negedge Clk);
        Start = 1'b1;
        In    = a;
        Sel   = s;
        @(posedge Clk);
        #1;
        Start    = 1'b0;
        In       = ~a;
        Sel      = s ^ 32'h0000_0007;
        busy_acc = Busy;
        lat      = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                lat = i;
                break;
            end
        end
        res       = Out;
        busy_done = Busy;
        @(posedge Clk);
        #1;
        done_after = Done;
        out_after  = Out;
    endtask

    initial begin
        int          lat;
        int          dones;
        int          pat_err;
        int          p;
        logic [31:0] res;
        logic [31:0] out_after;
        logic [31:0] done_out;
        logic        busy_acc;
        logic        busy_done;
        logic        done_after;

        vecs[0] = '{"sel0",        32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 0};
        vecs[1] = '{"ones_sel3",   32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFF8, 3};
        vecs[2] = '{"sel31",       32'h8000_0001, 32'h0000_001F, 32'h8000_0000, 31};
        vecs[3] = '{"sel32_sat",   32'h1234_5678, 32'h0000_0020, 32'h0000_0000, 0};
        vecs[4] = '{"a5_sel4",     32'hA5A5_A5A5, 32'h0000_0004, 32'h5A5A_5A50, 4};
        vecs[5] = '{"one_sel5",    32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 5};
        vecs[6] = '{"half_sel16",  32'h0000_FFFF, 32'h0000_0010, 32'hFFFF_0000, 16};
        vecs[7] = '{"dead_sel8",   32'hDEAD_BEEF, 32'h0000_0008, 32'hADBE_EF00, 8};
        vecs[8] = '{"selmax_sat",  32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000, 0};
        vecs[9] = '{"one_sel30",   32'h0000_0001, 32'h0000_001E, 32'h4000_0000, 30};

        Rst   = 1'b1;
        Start = 1'b1;
        In    = 32'hFFFF_FFFF;
        Sel   = 32'd1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_out",  Out,  32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        Rst   = 1'b0;
        Start = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].s, lat, res, busy_acc, busy_done, done_after, out_after);
            check({vecs[i].name, "_out"},       res, vecs[i].exp_out);
            check({vecs[i].name, "_latency"},   lat, exp_k(vecs[i].n) + 1);
            check({vecs[i].name, "_busy_acc"},  {31'd0, busy_acc}, 32'd1);
            check({vecs[i].name, "_busy_done"}, {31'd0, busy_done}, 32'd0);
            check({vecs[i].name, "_done_1cyc"}, {31'd0, done_after}, 32'd0);
            check({vecs[i].name, "_out_hold"},  out_after, vecs[i].exp_out);
        end

        // Second Start while busy must be dropped entirely.
        @(negedge Clk);
        Start = 1'b1;
        In    = 32'h0000_0003;
        Sel   = 32'd1;
        @(posedge Clk);
        #1;
        In    = 32'hFFFF_FFFF;
        Sel   = 32'd4;
        @(posedge Clk);
        #1;
        Start    = 1'b0;
        dones    = 0;
        done_out = 32'hX;
        if (Done) begin
            dones++;
            done_out = Out;
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                dones++;
                done_out = Out;
            end
        end
        check("busy_ignore_dones", dones, 32'd1);
        check("busy_ignore_out",   done_out, 32'h0000_0006);
        check("busy_ignore_idle",  {31'd0, Busy}, 32'd0);

        // Reset on the third edge (accept is edge one) aborts the operation.
        @(negedge Clk);
        Start = 1'b1;
        In    = 32'hFFFF_FFFF;
        Sel   = 32'd20;
        dones = 0;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(posedge Clk);
        #1;
        if (Done) dones++;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        if (Done) dones++;
        check("abort_out",  Out, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        Rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge Clk);
            #1;
            if (Done) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        run_op(32'h0000_0001, 32'd2, lat, res, busy_acc, busy_done, done_after, out_after);
        check("after_abort_out",     res, 32'h0000_0004);
        check("after_abort_latency", lat, exp_k(2) + 1);

        // Start held high: Done every k+2 edges, a new op accepted right after each Done.
        p       = exp_k(2) + 2;
        dones   = 0;
        pat_err = 0;
        @(negedge Clk);
        Start = 1'b1;
        In    = 32'h0000_0001;
        Sel   = 32'd2;
        for (int j = 1; j <= 40; j++) begin
            @(posedge Clk);
            #1;
            if (Done !== ((j % p) == 0)) pat_err++;
            if (Done) begin
                dones++;
                if (Out !== 32'h0000_0004) pat_err++;
            end
        end
        Start = 1'b0;
        check("b2b_pattern_errs", pat_err, 32'd0);
        check("b2b_done_count",   dones, 40 / p);
        repeat (p + 2) @(posedge Clk);
        #1;
        check("b2b_drained_busy", {31'd0, Busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected completion");
        $fatal(1, "watchdog");
    end

endmodule
